// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and constants for the fetch stage and instruction RAM
package cpu_pkg;
  localparam int CPU_ADDR_W = 12;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  typedef enum logic {RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: free-running fetch, stall and flush event counters (wrap at 2^32)
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  input  logic        flush_inc,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      fetch_cnt_o <= fetch_cnt_o + 32'(fetch_inc);
      stall_cnt_o <= stall_cnt_o + 32'(stall_inc);
      flush_cnt_o <= flush_cnt_o + 32'(flush_inc);
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencing with stall/redirect/halt and NOP bubble insertion.
// Define FETCH_PERF_CNT_EN to add fetch/stall/flush performance counters.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_ex_o,
  output logic [ADDR_W-1:0] pc_ex_o,
  output logic              valid_ex_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
`endif
  output logic              halted_o
);
  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc_f, pc_n, pc_ex_n;
  logic [31:0]       instr_n;
  logic              valid_n, adv, hold;
  // anything that is neither an advance nor a stall hold loads a bubble
  always_comb begin
    adv     = state == RUN && !redirect_i && !halt_i && !stall_i;
    hold    = state == RUN && !redirect_i && !halt_i && stall_i;
    state_n = redirect_i ? RUN : halt_i ? HALTED : state;
    pc_n    = redirect_i ? redirect_pc_i : adv ? pc_f + ADDR_W'(1) : pc_f;
    instr_n = adv ? imem_rdata_i : hold ? instr_ex_o : NOP_INSTR;
    pc_ex_n = adv ? pc_f : pc_ex_o;
    valid_n = adv || (hold && valid_ex_o);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= RUN;
      pc_f       <= RESET_PC;
      instr_ex_o <= NOP_INSTR;
      pc_ex_o    <= '0;
      valid_ex_o <= 1'b0;
    end else begin
      state      <= state_n;
      pc_f       <= pc_n;
      instr_ex_o <= instr_n;
      pc_ex_o    <= pc_ex_n;
      valid_ex_o <= valid_n;
    end
  assign imem_addr_o = pc_f;
  assign halted_o    = state == HALTED;
`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_inc   (adv),
    .stall_inc   (state == RUN && stall_i && !redirect_i),
    .flush_inc   (redirect_i),
    .fetch_cnt_o (fetch_cnt_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );
`endif
endmodule
